axi4_lite_reg_slave: RTL and testbench

AXI4-Lite responder that terminates the `axi4_lite_if` Slave modport in a bank of NUM_REGS software-visible registers. It accepts one write and one read at a time and applies byte strobes. Out-of-range accesses get SLVERR. It is the register-bank end for any block driven by an AXI4-Lite Master, and exposes register contents and per-register write pulses to the surrounding hardware.

---
 rtl/axi4_lite_if.sv | 41 ++++
 rtl/axi4_lite_reg_slave.sv | 151 +++++++++++++++
 tb/tb_axi4_lite_reg_slave.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/axi4_lite_if.sv
// AXI4-Lite bus bundle shared by register-bank masters and slaves.
interface axi4_lite_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   aw_addr;
  logic [2:0]          aw_prot;
  logic                aw_valid;
  logic                aw_ready;
  logic [DATA_W-1:0]   w_data;
  logic [DATA_W/8-1:0] w_strb;
  logic                w_valid;
  logic                w_ready;
  logic [1:0]          b_resp;
  logic                b_valid;
  logic                b_ready;
  logic [ADDR_W-1:0]   ar_addr;
  logic [2:0]          ar_prot;
  logic                ar_valid;
  logic                ar_ready;
  logic [DATA_W-1:0]   r_data;
  logic [1:0]          r_resp;
  logic                r_valid;
  logic                r_ready;

  modport Master (
    output aw_addr, aw_prot, aw_valid, input aw_ready,
    output w_data, w_strb, w_valid, input w_ready,
    input b_resp, b_valid, output b_ready,
    output ar_addr, ar_prot, ar_valid, input ar_ready,
    input r_data, r_resp, r_valid, output r_ready
  );

  modport Slave (
    input aw_addr, aw_prot, aw_valid, output aw_ready,
    input w_data, w_strb, w_valid, output w_ready,
    output b_resp, b_valid, input b_ready,
    input ar_addr, ar_prot, ar_valid, output ar_ready,
    output r_data, r_resp, r_valid, input r_ready
  );
endinterface

// File: rtl/axi4_lite_reg_slave.sv
// AXI4-Lite register bank: NUM_REGS byte-strobed registers, one write and one
// read in flight at a time, SLVERR for indices past the bank.
module axi4_lite_reg_slave #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32,
  parameter int NUM_REGS = 16,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input  logic                         clk,
  input  logic                         rst,
  axi4_lite_if.Slave                   s_axi,
  output logic [NUM_REGS*DATA_W-1:0]   reg_o,
  output logic [NUM_REGS-1:0]          wr_pulse_o
);
  localparam int NBYTES = DATA_W / 8;
  localparam int OFF_W  = $clog2(NBYTES);
  localparam int IDX_W  = ADDR_W - OFF_W;
  localparam logic [IDX_W:0] NUM_REGS_L = (IDX_W + 1)'(NUM_REGS);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {WR_RST, WR_IDLE, WR_GOT_AW, WR_GOT_W, WR_RESP} wr_state_t;
  typedef enum logic [1:0] {RD_RST, RD_IDLE, RD_RESP} rd_state_t;

  wr_state_t wr_state, wr_next;
  rd_state_t rd_state, rd_next;

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic [IDX_W-1:0]  aw_idx_q;
  logic [DATA_W-1:0] w_data_q;
  logic [NBYTES-1:0] w_strb_q;

  logic              aw_hs, w_hs, ar_hs, wr_commit;
  logic [IDX_W-1:0]  wr_idx, rd_idx;
  logic [DATA_W-1:0] wr_data, rd_val;
  logic [NBYTES-1:0] wr_strb;
  logic              wr_in_range, rd_in_range;
  logic              unused_bits;

  assign unused_bits = ^{s_axi.aw_prot, s_axi.ar_prot,
                         s_axi.aw_addr[OFF_W-1:0], s_axi.ar_addr[OFF_W-1:0]};

  // The commit takes whichever half arrives live this cycle and the latched
  // copy of the other half, so both arrival orders share one commit path.
  always_comb begin
    aw_hs     = s_axi.aw_valid & s_axi.aw_ready;
    w_hs      = s_axi.w_valid & s_axi.w_ready;
    ar_hs     = s_axi.ar_valid & s_axi.ar_ready;
    wr_commit = (aw_hs & w_hs) | (aw_hs & (wr_state == WR_GOT_W))
              | (w_hs & (wr_state == WR_GOT_AW));
    wr_idx    = (wr_state == WR_GOT_AW) ? aw_idx_q : s_axi.aw_addr[ADDR_W-1:OFF_W];
    wr_data   = (wr_state == WR_GOT_W) ? w_data_q : s_axi.w_data;
    wr_strb   = (wr_state == WR_GOT_W) ? w_strb_q : s_axi.w_strb;
    wr_in_range = {1'b0, wr_idx} < NUM_REGS_L;
    rd_idx      = s_axi.ar_addr[ADDR_W-1:OFF_W];
    rd_in_range = {1'b0, rd_idx} < NUM_REGS_L;
  end

  always_comb begin
    rd_val = '0;
    reg_o  = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      reg_o[i*DATA_W +: DATA_W] = regs[i];
      if (rd_idx == IDX_W'(i)) rd_val = regs[i];
    end
  end

  // Write channel FSM
  always_ff @(posedge clk) begin
    if (rst) wr_state <= WR_RST;
    else     wr_state <= wr_next;
  end

  always_comb begin
    wr_next = wr_state;
    unique case (wr_state)
      WR_RST:    wr_next = WR_IDLE;
      WR_IDLE: begin
        if (aw_hs && w_hs) wr_next = WR_RESP;
        else if (aw_hs)    wr_next = WR_GOT_AW;
        else if (w_hs)     wr_next = WR_GOT_W;
      end
      WR_GOT_AW: if (w_hs)  wr_next = WR_RESP;
      WR_GOT_W:  if (aw_hs) wr_next = WR_RESP;
      WR_RESP:   if (s_axi.b_ready) wr_next = WR_IDLE;
      default:   wr_next = WR_RST;
    endcase
  end

  always_comb begin
    s_axi.aw_ready = (wr_state == WR_IDLE) || (wr_state == WR_GOT_W);
    s_axi.w_ready  = (wr_state == WR_IDLE) || (wr_state == WR_GOT_AW);
    s_axi.b_valid  = (wr_state == WR_RESP);
  end

  // Read channel FSM
  always_ff @(posedge clk) begin
    if (rst) rd_state <= RD_RST;
    else     rd_state <= rd_next;
  end

  always_comb begin
    rd_next = rd_state;
    unique case (rd_state)
      RD_RST:  rd_next = RD_IDLE;
      RD_IDLE: if (ar_hs) rd_next = RD_RESP;
      RD_RESP: if (s_axi.r_ready) rd_next = RD_IDLE;
      default: rd_next = RD_RST;
    endcase
  end

  always_comb begin
    s_axi.ar_ready = (rd_state == RD_IDLE);
    s_axi.r_valid  = (rd_state == RD_RESP);
  end

  // Datapath: latches, register bank, responses
  always_ff @(posedge clk) begin
    if (rst) begin
      aw_idx_q     <= '0;
      w_data_q     <= '0;
      w_strb_q     <= '0;
      s_axi.b_resp <= RESP_OKAY;
      s_axi.r_data <= '0;
      s_axi.r_resp <= RESP_OKAY;
      wr_pulse_o   <= '0;
      for (int unsigned i = 0; i < NUM_REGS; i++) regs[i] <= RESET_VAL;
    end else begin
      wr_pulse_o <= '0;
      if (aw_hs) aw_idx_q <= s_axi.aw_addr[ADDR_W-1:OFF_W];
      if (w_hs) begin
        w_data_q <= s_axi.w_data;
        w_strb_q <= s_axi.w_strb;
      end
      if (wr_commit) begin
        s_axi.b_resp <= wr_in_range ? RESP_OKAY : RESP_SLVERR;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
          if (wr_in_range && (wr_idx == IDX_W'(i))) begin
            wr_pulse_o[i] <= 1'b1;
            for (int unsigned b = 0; b < NBYTES; b++)
              if (wr_strb[b]) regs[i][b*8 +: 8] <= wr_data[b*8 +: 8];
          end
        end
      end
      if (ar_hs) begin
        s_axi.r_data <= rd_in_range ? rd_val : '0;
        s_axi.r_resp <= rd_in_range ? RESP_OKAY : RESP_SLVERR;
      end
    end
  end
endmodule

// File: tb/tb_axi4_lite_reg_slave.sv
// Directed bench for axi4_lite_reg_slave (ADDR_W=16, DATA_W=32, NUM_REGS=16).
module tb_axi4_lite_reg_slave;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [511:0] reg_o;
  logic [15:0]  wr_pulse_o;
  logic [511:0] exp_regs;
  int tests = 0;
  int fails = 0;

  axi4_lite_if #(.ADDR_W(16), .DATA_W(32)) bus ();

  axi4_lite_reg_slave #(
    .ADDR_W(16), .DATA_W(32), .NUM_REGS(16), .RESET_VAL(32'h0)
  ) dut (
    .clk(clk), .rst(rst), .s_axi(bus), .reg_o(reg_o), .wr_pulse_o(wr_pulse_o)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic axi_write(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s,
                           input logic [1:0] exp_resp, input logic [15:0] exp_pulse);
    int n;
    logic aw_hs, w_hs;
    bus.aw_addr = a; bus.aw_valid = 1'b1;
    bus.w_data = d; bus.w_strb = s; bus.w_valid = 1'b1;
    bus.b_ready = 1'b1;
    n = 0;
    while ((bus.aw_valid || bus.w_valid) && n < 20) begin
      aw_hs = bus.aw_valid && bus.aw_ready;
      w_hs  = bus.w_valid && bus.w_ready;
      step();
      if (aw_hs) bus.aw_valid = 1'b0;
      if (w_hs)  bus.w_valid = 1'b0;
      n++;
    end
    check("wr_handshakes_done", {bus.aw_valid, bus.w_valid}, 2'b00);
    check("wr_b_valid", bus.b_valid, 1'b1);
    check("wr_b_resp", bus.b_resp, exp_resp);
    check("wr_pulse", wr_pulse_o, exp_pulse);
    step();
    bus.b_ready = 1'b0;
    check("wr_b_valid_clear", bus.b_valid, 1'b0);
    check("wr_pulse_clear", wr_pulse_o, 16'h0);
    check("wr_readys_back", {bus.aw_ready, bus.w_ready}, 2'b11);
  endtask

  task automatic axi_read(input logic [15:0] a, input logic [31:0] exp_data,
                          input logic [1:0] exp_resp);
    int n;
    bus.ar_addr = a; bus.ar_valid = 1'b1; bus.r_ready = 1'b1;
    n = 0;
    while (!bus.ar_ready && n < 20) begin
      step();
      n++;
    end
    check("rd_ar_ready", bus.ar_ready, 1'b1);
    step();
    bus.ar_valid = 1'b0;
    check("rd_r_valid", bus.r_valid, 1'b1);
    check("rd_r_data", bus.r_data, exp_data);
    check("rd_r_resp", bus.r_resp, exp_resp);
    step();
    bus.r_ready = 1'b0;
    check("rd_r_valid_clear", bus.r_valid, 1'b0);
    check("rd_ar_ready_back", bus.ar_ready, 1'b1);
  endtask

  initial begin
    bus.aw_addr = '0; bus.aw_prot = '0; bus.aw_valid = 1'b0;
    bus.w_data = '0; bus.w_strb = '0; bus.w_valid = 1'b0; bus.b_ready = 1'b0;
    bus.ar_addr = '0; bus.ar_prot = '0; bus.ar_valid = 1'b0; bus.r_ready = 1'b0;

    // Reset state
    repeat (3) step();
    check("rst_readys", {bus.aw_ready, bus.w_ready, bus.ar_ready}, 3'b000);
    check("rst_b", {bus.b_valid, bus.b_resp}, 3'b000);
    check("rst_r", {bus.r_valid, bus.r_resp, bus.r_data}, 35'h0);
    check("rst_pulse", wr_pulse_o, 16'h0);
    check("rst_regs", reg_o, 512'h0);
    rst = 1'b0;
    step();
    check("post_rst_readys", {bus.aw_ready, bus.w_ready, bus.ar_ready}, 3'b111);

    // Every register reads RESET_VAL
    for (int i = 0; i < 16; i++) axi_read(16'(i * 4), 32'h0, 2'b00);

    // Byte-strobed writes to register 2
    axi_write(16'h0008, 32'hAABBCCDD, 4'hF, 2'b00, 16'h0004);
    axi_write(16'h0008, 32'h11223344, 4'b0101, 2'b00, 16'h0004);
    check("strb_reg2", reg_o[95:64], 32'hAA22CC44);
    axi_read(16'h0008, 32'hAA22CC44, 2'b00);

    // W three cycles before AW
    bus.w_data = 32'h5A5A5A5A; bus.w_strb = 4'hF; bus.w_valid = 1'b1;
    step();
    bus.w_valid = 1'b0;
    check("wfirst_w_ready_low", {bus.aw_ready, bus.w_ready, bus.b_valid}, 3'b100);
    step();
    step();
    check("wfirst_still_waiting", {bus.w_ready, bus.b_valid, reg_o[63:32]}, 34'h0);
    bus.aw_addr = 16'h0004; bus.aw_valid = 1'b1;
    step();
    bus.aw_valid = 1'b0;
    check("wfirst_b_valid", {bus.b_valid, bus.b_resp}, 3'b100);
    check("wfirst_reg1", reg_o[63:32], 32'h5A5A5A5A);
    check("wfirst_pulse", wr_pulse_o, 16'h0002);
    check("wfirst_readys_low", {bus.aw_ready, bus.w_ready}, 2'b00);
    bus.b_ready = 1'b1;
    step();
    bus.b_ready = 1'b0;
    check("wfirst_readys_back", {bus.aw_ready, bus.w_ready, bus.b_valid}, 3'b110);

    // AW three cycles before W
    bus.aw_addr = 16'h0004; bus.aw_valid = 1'b1;
    step();
    bus.aw_valid = 1'b0;
    check("awfirst_aw_ready_low", {bus.aw_ready, bus.w_ready, bus.b_valid}, 3'b010);
    step();
    step();
    bus.w_data = 32'hA5A5A5A5; bus.w_strb = 4'hF; bus.w_valid = 1'b1;
    step();
    bus.w_valid = 1'b0;
    check("awfirst_b_valid", {bus.b_valid, bus.b_resp}, 3'b100);
    check("awfirst_reg1", reg_o[63:32], 32'hA5A5A5A5);
    check("awfirst_pulse", wr_pulse_o, 16'h0002);
    bus.b_ready = 1'b1;
    step();
    bus.b_ready = 1'b0;
    check("awfirst_readys_back", {bus.aw_ready, bus.w_ready}, 2'b11);

    // AW and W together
    axi_write(16'h0004, 32'h5A5A5A5A, 4'hF, 2'b00, 16'h0002);
    check("together_reg1", reg_o[63:32], 32'h5A5A5A5A);

    // Out of range
    exp_regs = '0;
    exp_regs[63:32] = 32'h5A5A5A5A;
    exp_regs[95:64] = 32'hAA22CC44;
    axi_write(16'h0040, 32'hFFFFFFFF, 4'hF, 2'b10, 16'h0000);
    check("oor_regs_unchanged", reg_o, exp_regs);
    axi_read(16'h0040, 32'h0, 2'b10);

    // Backpressure on B and R, write to reg 3 and read of reg 2 in parallel
    bus.aw_addr = 16'h000C; bus.aw_valid = 1'b1;
    bus.w_data = 32'h12345678; bus.w_strb = 4'hF; bus.w_valid = 1'b1;
    bus.ar_addr = 16'h0008; bus.ar_valid = 1'b1;
    step();
    bus.aw_valid = 1'b0; bus.w_valid = 1'b0; bus.ar_valid = 1'b0;
    for (int c = 0; c < 5; c++) begin
      check("bp_b", {bus.b_valid, bus.b_resp}, 3'b100);
      check("bp_r", {bus.r_valid, bus.r_resp, bus.r_data}, {1'b1, 2'b00, 32'hAA22CC44});
      check("bp_readys", {bus.aw_ready, bus.w_ready, bus.ar_ready}, 3'b000);
      step();
    end
    bus.b_ready = 1'b1; bus.r_ready = 1'b1;
    check("bp_hs_cycle_readys", {bus.aw_ready, bus.w_ready, bus.ar_ready}, 3'b000);
    step();
    bus.b_ready = 1'b0; bus.r_ready = 1'b0;
    check("bp_valids_clear", {bus.b_valid, bus.r_valid}, 2'b00);
    check("bp_readys_back", {bus.aw_ready, bus.w_ready, bus.ar_ready}, 3'b111);
    check("bp_reg3", reg_o[127:96], 32'h12345678);

    // Read and write of reg 3 on the same edge
    bus.aw_addr = 16'h000C; bus.aw_valid = 1'b1;
    bus.w_data = 32'hCAFEF00D; bus.w_strb = 4'hF; bus.w_valid = 1'b1;
    bus.ar_addr = 16'h000C; bus.ar_valid = 1'b1;
    step();
    bus.aw_valid = 1'b0; bus.w_valid = 1'b0; bus.ar_valid = 1'b0;
    check("coll_old_value", {bus.r_valid, bus.r_data}, {1'b1, 32'h12345678});
    check("coll_reg3_new", reg_o[127:96], 32'hCAFEF00D);
    bus.b_ready = 1'b1; bus.r_ready = 1'b1;
    step();
    bus.b_ready = 1'b0; bus.r_ready = 1'b0;
    axi_read(16'h000C, 32'hCAFEF00D, 2'b00);

    // Reset with a write response pending
    bus.aw_addr = 16'h0000; bus.aw_valid = 1'b1;
    bus.w_data = 32'h00000001; bus.w_strb = 4'hF; bus.w_valid = 1'b1;
    step();
    bus.aw_valid = 1'b0; bus.w_valid = 1'b0;
    check("mid_b_pending", bus.b_valid, 1'b1);
    rst = 1'b1;
    step();
    check("mid_rst_b_valid", bus.b_valid, 1'b0);
    check("mid_rst_readys", {bus.aw_ready, bus.w_ready, bus.ar_ready}, 3'b000);
    check("mid_rst_regs", reg_o, 512'h0);
    rst = 1'b0;
    step();
    check("mid_post_readys", {bus.aw_ready, bus.w_ready, bus.ar_ready}, 3'b111);
    check("mid_post_no_resp", {bus.b_valid, bus.r_valid}, 2'b00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
